eth_video_frame_writer: RTL and testbench
=========================================

# eth_video_frame_writer

Pixel-to-frame stage directly downstream of the Ethernet UDP video receiver. It consumes the receiver's 24-bit pixel word strobe and packet-done pulse, and locks to frames using a tag word at the start of a packet. It assigns each pixel a linear frame-buffer address and emits write requests toward the DDR frame-buffer writer, plus line and frame events and frame error reporting.

## Interface
- `H_ACT`, 1280, active pixels per line.
- `V_ACT`, 720, active lines per frame.
- `ADDR_W`, 20, pixel address width; must satisfy H_ACT*V_ACT <= 2^ADDR_W.
- `FRAME_TAG`, 24'hA5_5A_F0, first 24-bit word of a frame-start packet.
- `clk`  in  1  receive clock, same domain as the UDP receiver.
- `rst_n`  in  1  asynchronous active-low reset.
- `eth_rec_en`  in  1  one-cycle strobe; `rec_data_24` valid.
- `rec_data_24`  in  24  pixel word, {R,G,B}, first byte in [23:16].
- `rec_pkt_done`  in  1  one-cycle pulse on the last payload byte of a packet.
- `wr_en`  out  1  pixel write strobe.
- `wr_addr`  out  ADDR_W  linear pixel address, y*H_ACT + x.
- `wr_data`  out  24  pixel data; format per Configuration.
- `line_done`  out  1  pulse with the write of pixel x = H_ACT-1.
- `frame_done`  out  1  pulse with the write of the last pixel of the frame.
- `frame_err`  out  1  pulse when a frame is aborted by a new tag.
- `frame_busy`  out  1  high while locked inside a frame.

## Operation
- `pkt_first` flag: set by reset and by `rec_pkt_done`. Cleared by any `eth_rec_en` that occurs without `rec_pkt_done` in the same cycle.
- FSM has two states:
  - ST_SYNC (reset state): waiting for a tag.
  - ST_RUN: inside a frame.
- Tag detection: `eth_rec_en` && `pkt_first` && `rec_data_24 == FRAME_TAG`.
  - The tag word is consumed and never written.
  - Clears x, y and the address counter, and moves the FSM to ST_RUN.
  - If the FSM was already in ST_RUN, also pulse `frame_err`.
- ST_SYNC: every non-tag word is dropped silently.
- ST_RUN: every non-tag word is written at the current address.
  - x increments on each write.
  - At x = H_ACT-1: x returns to 0, y increments, `line_done` pulses.
  - At x = H_ACT-1 and y = V_ACT-1: `frame_done` pulses and the FSM returns to ST_SYNC. Further pixels are dropped until the next tag.
- Address is a running counter incremented per write; no multiplier. It is equal to y*H_ACT + x by construction.
- A tag word appearing mid-packet (`pkt_first` = 0) is treated as an ordinary pixel.
- Simultaneous `eth_rec_en` and `rec_pkt_done`: the word is evaluated with the pre-existing `pkt_first`, then `pkt_first` is set.

## Timing
- Registered outputs. `wr_en`, `wr_addr`, `wr_data`, `line_done`, `frame_done` and `frame_err` assert one cycle after the qualifying `eth_rec_en`.
- `frame_busy` follows the FSM state register.
- Reset values: all outputs 0; FSM in ST_SYNC; `pkt_first` = 1; x, y and address = 0.
- No backpressure: the downstream must accept one write per cycle. Inputs arrive at most one word every 3 cycles.
- Reset asserted mid-frame: all state clears immediately. No partial-frame event is emitted; the next tag resynchronises.
- A tag arriving in the same cycle that would otherwise complete a frame cannot occur, because the tag is never a pixel.

## Configuration
- `ETH_VIDEO_RGB565_EN` defined:
  - `wr_data` = {8'd0, R[7:3], G[7:2], B[7:3]}.
  - `wr_addr` unchanged, since it is a pixel address.
- Macro undefined: `wr_data` = `rec_data_24` passed through unchanged.

## Structure
- Shared package `eth_video_pkg` holds:
  - the FSM state encoding (ST_SYNC, ST_RUN);
  - the default FRAME_TAG constant;
  - the default H_ACT/V_ACT constants, which are shared with the UDP receiver and the frame-buffer writer.
- The RGB565 packing is a pure function in the package; there is no sub-module.
- The block is a single module; no sub-module is needed.

## Test plan
- Reset, then one tag packet followed by H_ACT*V_ACT pixels split across 1024-pixel packets:
  - `wr_addr` runs 0..921599;
  - 720 `line_done` pulses;
  - one `frame_done` on address 921599;
  - `frame_busy` drops after it.
- Pixels sent before any tag: no `wr_en`, `frame_busy` stays 0.
- Tag mid-frame after 5000 pixels: `frame_err` pulse, next pixel written at `wr_addr` 0.
- Value equal to FRAME_TAG as the second word of a packet: written as a pixel at the expected address; no resync.
- `eth_rec_en` coincident with `rec_pkt_done`, followed by a tag in the next packet: the coincident word is written and the tag is recognised.
- With `ETH_VIDEO_RGB565_EN` defined, pixel 24'hFF8040 -> `wr_data` 24'h00FC08; without the macro -> 24'hFF8040.

Source files
------------

// File: rtl/eth_video_pkg.sv
// Shared definitions for the Ethernet video path: FSM encoding, default
// geometry, frame tag and the RGB565 packing helper.
package eth_video_pkg;

    localparam int unsigned H_ACT_DEF     = 1280;
    localparam int unsigned V_ACT_DEF     = 720;
    localparam int unsigned ADDR_W_DEF    = 20;
    localparam logic [23:0] FRAME_TAG_DEF = 24'hA5_5A_F0;

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } fw_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Pack a 24-bit RGB888 pixel into RGB565, zero-extended to 24 bits.
    function automatic logic [23:0] rgb565_pack(input pixel_t px);
        return {8'd0, px.r[7:3], px.g[7:2], px.b[7:3]};
    endfunction

endpackage

// File: rtl/eth_video_frame_writer_if.sv
// Receiver-to-writer bus: pixel word strobe in, frame-buffer write requests
// and frame events out. master = receiver/DDR side, slave = frame writer.
interface eth_video_frame_writer_if #(
    parameter int unsigned ADDR_W = 20
);
    logic              eth_rec_en;
    logic [23:0]       rec_data_24;
    logic              rec_pkt_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              line_done;
    logic              frame_done;
    logic              frame_err;
    logic              frame_busy;

    modport master (
        output eth_rec_en, rec_data_24, rec_pkt_done,
        input  wr_en, wr_addr, wr_data, line_done, frame_done, frame_err, frame_busy
    );

    modport slave (
        input  eth_rec_en, rec_data_24, rec_pkt_done,
        output wr_en, wr_addr, wr_data, line_done, frame_done, frame_err, frame_busy
    );
endinterface

// File: rtl/eth_video_frame_writer.sv
// Locks to frames on a tag word at the start of a packet and turns the UDP
// receiver's pixel strobe into linear frame-buffer write requests with line,
// frame and abort events. Optional feature macro: ETH_VIDEO_RGB565_EN packs
// wr_data to RGB565; otherwise pixels pass through as RGB888.
module eth_video_frame_writer
    import eth_video_pkg::*;
#(
    parameter int unsigned H_ACT     = H_ACT_DEF,
    parameter int unsigned V_ACT     = V_ACT_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter logic [23:0] FRAME_TAG = FRAME_TAG_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eth_video_frame_writer_if.slave  bus
);

    localparam int unsigned X_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned Y_W = (V_ACT > 1) ? $clog2(V_ACT) : 1;

    fw_state_e         state_q, state_d;
    logic              pkt_first_q, pkt_first_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              line_done_q, line_done_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;

    logic              tag_hit;
    logic              pix_wr;
    logic              x_last;
    logic              y_last;
    logic [23:0]       pix_fmt;

    // Word classification: a tag only counts as the first word of a packet.
    assign tag_hit = bus.eth_rec_en && pkt_first_q && (bus.rec_data_24 == FRAME_TAG);
    assign pix_wr  = bus.eth_rec_en && !tag_hit && (state_q == ST_RUN);
    assign x_last  = (x_q == X_W'(H_ACT - 1));
    assign y_last  = (y_q == Y_W'(V_ACT - 1));

`ifdef ETH_VIDEO_RGB565_EN
    assign pix_fmt = rgb565_pack(pixel_t'(bus.rec_data_24));
`else
    assign pix_fmt = bus.rec_data_24;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a tag always (re)enters a frame; the last pixel leaves it.
    always_comb begin
        state_d = state_q;
        if (tag_hit) begin
            state_d = ST_RUN;
        end else if (pix_wr && x_last && y_last) begin
            state_d = ST_SYNC;
        end
    end

    // Datapath and output next values: counters, write request and events.
    always_comb begin
        pkt_first_d  = pkt_first_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        // Packet-done wins over a coincident word so the next packet starts fresh.
        if (bus.rec_pkt_done) begin
            pkt_first_d = 1'b1;
        end else if (bus.eth_rec_en) begin
            pkt_first_d = 1'b0;
        end

        if (tag_hit) begin
            x_d         = '0;
            y_d         = '0;
            addr_d      = '0;
            frame_err_d = (state_q == ST_RUN);
        end else if (pix_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pix_fmt;
            addr_d    = addr_q + ADDR_W'(1);
            if (x_last) begin
                x_d         = '0;
                line_done_d = 1'b1;
                if (y_last) begin
                    y_d          = '0;
                    addr_d       = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = y_q + Y_W'(1);
                end
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_first_q  <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            pkt_first_q  <= pkt_first_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.line_done  = line_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_eth_video_frame_writer.sv
// Scoreboard bench for eth_video_frame_writer on a reduced frame geometry.
module tb_eth_video_frame_writer;

    localparam int unsigned H  = 32;
    localparam int unsigned V  = 8;
    localparam int unsigned AW = 20;
    localparam logic [23:0] TAG = 24'hA5_5A_F0;
`ifdef ETH_VIDEO_RGB565_EN
    localparam logic [23:0] RGB_EXP = 24'h00FC08;
`else
    localparam logic [23:0] RGB_EXP = 24'hFF8040;
`endif

    typedef struct {
        bit          wr;
        bit          err;
        bit          line;
        bit          frame;
        logic [31:0] addr;
        logic [23:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_tests;
    int   n_fail;
    int   obs_lines;
    int   obs_frames;
    int   exp_lines;
    int   exp_frames;

    // Reference model state
    bit   m_run;
    bit   m_pkt_first;
    int   m_x;
    int   m_y;

    eth_video_frame_writer_if #(.ADDR_W(AW)) bus ();

    eth_video_frame_writer #(
        .H_ACT     (H),
        .V_ACT     (V),
        .ADDR_W    (AW),
        .FRAME_TAG (TAG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_fmt(input logic [23:0] d);
`ifdef ETH_VIDEO_RGB565_EN
        return {8'h00, d[23:19], d[15:10], d[7:3]};
`else
        return d;
`endif
    endfunction

    function automatic logic [23:0] rnd_pix();
        logic [23:0] p;
        p = 24'($urandom);
        if (p == TAG) p = p ^ 24'h1;
        return p;
    endfunction

    // Predict the outcome of one word, then drive it for one cycle and idle two.
    task automatic send_word(input logic [23:0] d, input bit done);
        exp_t e;
        bit   push;
        e = '{default: '0};
        push = 0;
        if (m_pkt_first && d == TAG) begin
            if (m_run) begin
                e.err = 1;
                push  = 1;
            end
            m_run = 1;
            m_x   = 0;
            m_y   = 0;
        end else if (m_run) begin
            e.wr    = 1;
            e.addr  = 32'(m_y * H + m_x);
            e.data  = exp_fmt(d);
            e.line  = (m_x == H - 1);
            e.frame = e.line && (m_y == V - 1);
            push    = 1;
            if (e.line) exp_lines++;
            if (e.frame) exp_frames++;
            if (e.frame) begin
                m_run = 0;
                m_x   = 0;
                m_y   = 0;
            end else if (e.line) begin
                m_x = 0;
                m_y = m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
        m_pkt_first = done;
        if (push) q.push_back(e);

        bus.eth_rec_en   = 1'b1;
        bus.rec_data_24  = d;
        bus.rec_pkt_done = done;
        @(posedge clk);
        #1;
        bus.eth_rec_en   = 1'b0;
        bus.rec_data_24  = 24'h0;
        bus.rec_pkt_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every output event must match the oldest prediction.
    always @(negedge clk) begin
        if (rst_n && (bus.wr_en || bus.line_done || bus.frame_done || bus.frame_err)) begin
            if (bus.line_done) obs_lines++;
            if (bus.frame_done) obs_frames++;
            if (q.size() == 0) begin
                chk("unexpected_output", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_en", 32'(bus.wr_en), 32'(e.wr));
                chk("frame_err", 32'(bus.frame_err), 32'(e.err));
                chk("line_done", 32'(bus.line_done), 32'(e.line));
                chk("frame_done", 32'(bus.frame_done), 32'(e.frame));
                if (e.wr) begin
                    chk("wr_addr", 32'(bus.wr_addr), e.addr);
                    chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        obs_lines = 0; obs_frames = 0; exp_lines = 0; exp_frames = 0;
        m_run = 0; m_pkt_first = 1; m_x = 0; m_y = 0;
        rst_n = 1'b0;
        bus.eth_rec_en = 1'b0;
        bus.rec_data_24 = 24'h0;
        bus.rec_pkt_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
        chk("rst_wr_data", 32'(bus.wr_data), 32'(0));
        chk("rst_busy", 32'(bus.frame_busy), 32'(0));
        chk("rst_events", 32'({bus.line_done, bus.frame_done, bus.frame_err}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pixels before any tag are dropped
        for (int i = 0; i < 6; i++) send_word(rnd_pix(), i == 5);
        chk("pre_tag_busy", 32'(bus.frame_busy), 32'(0));

        // Full frame: tag packet then H*V pixels in 24-pixel packets
        send_word(TAG, 1'b1);
        chk("tag_busy", 32'(bus.frame_busy), 32'(1));
        for (int i = 0; i < H * V; i++) begin
            send_word((i == 0) ? 24'hFF8040 : rnd_pix(), (i % 24 == 23) || (i == H * V - 1));
            if (i == 0) chk("rgb_const", 32'(bus.wr_data), 32'(RGB_EXP));
        end
        chk("frame_end_busy", 32'(bus.frame_busy), 32'(0));
        chk("frame_end_addr", 32'(bus.wr_addr), 32'(H * V - 1));
        // Post-frame pixels without a new tag are dropped
        for (int i = 0; i < 3; i++) send_word(rnd_pix(), i == 2);
        chk("post_frame_busy", 32'(bus.frame_busy), 32'(0));

        // Tag mid-frame aborts and restarts at address 0
        send_word(TAG, 1'b1);
        for (int i = 0; i < 100; i++) send_word(rnd_pix(), (i % 24 == 23) || (i == 99));
        send_word(TAG, 1'b1);
        send_word(rnd_pix(), 1'b0);
        chk("resync_addr", 32'(bus.wr_addr), 32'(0));

        // Tag value mid-packet is an ordinary pixel
        send_word(TAG, 1'b0);
        chk("tag_as_pixel_addr", 32'(bus.wr_addr), 32'(1));
        chk("tag_as_pixel_data", 32'(bus.wr_data), 32'(exp_fmt(TAG)));
        chk("tag_as_pixel_busy", 32'(bus.frame_busy), 32'(1));

        // Word coincident with packet done is written; next-packet tag resyncs
        send_word(rnd_pix(), 1'b1);
        chk("coinc_addr", 32'(bus.wr_addr), 32'(2));
        send_word(TAG, 1'b1);
        send_word(rnd_pix(), 1'b0);
        chk("coinc_resync_addr", 32'(bus.wr_addr), 32'(0));
        for (int i = 0; i < 40; i++) send_word(rnd_pix(), i == 39);

        // Reset mid-frame clears everything immediately
        chk("pre_reset_busy", 32'(bus.frame_busy), 32'(1));
        rst_n = 1'b0;
        #2;
        chk("mid_reset_busy", 32'(bus.frame_busy), 32'(0));
        chk("mid_reset_addr", 32'(bus.wr_addr), 32'(0));
        m_run = 0; m_pkt_first = 1; m_x = 0; m_y = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_word(rnd_pix(), i == 2);
        chk("post_reset_busy", 32'(bus.frame_busy), 32'(0));
        send_word(TAG, 1'b1);
        chk("post_reset_err_free", 32'(bus.frame_err), 32'(0));
        send_word(rnd_pix(), 1'b0);
        chk("post_reset_addr", 32'(bus.wr_addr), 32'(0));

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'(0));
        chk("line_count", 32'(obs_lines), 32'(exp_lines));
        chk("frame_count", 32'(obs_frames), 32'(exp_frames));
        chk("frame_count_abs", 32'(obs_frames), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
